// File: rtl/char_row_writer_pkg.sv
// ----------------------------------------------------------------------------
// char_pkg
// Shared constants and types for the character row writer.
//   - Widths of the host byte, glyph code and cell address.
//   - Glyph code constants (blank cell, digit and letter bases).
//   - ASCII control codes handled by the writer (CR, BS, FF).
//   - FSM state encoding.
// ----------------------------------------------------------------------------
package char_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned GLYPH_W = 6;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned MAX_COLS = 64;

    // Glyph codes
    localparam logic [GLYPH_W-1:0] BLANK_CODE    = 6'h3F;
    localparam logic [GLYPH_W-1:0] GLYPH_DIGIT0  = 6'd0;
    localparam logic [GLYPH_W-1:0] GLYPH_ALPHA_A = 6'd10;

    // ASCII control and range boundaries
    localparam logic [BYTE_W-1:0] CR          = 8'h0D;
    localparam logic [BYTE_W-1:0] BS          = 8'h08;
    localparam logic [BYTE_W-1:0] FF          = 8'h0C;
    localparam logic [BYTE_W-1:0] ASCII_SPACE = 8'h20;
    localparam logic [BYTE_W-1:0] ASCII_0     = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_9     = 8'h39;
    localparam logic [BYTE_W-1:0] ASCII_UC_A  = 8'h41;
    localparam logic [BYTE_W-1:0] ASCII_UC_Z  = 8'h5A;
    localparam logic [BYTE_W-1:0] ASCII_LC_A  = 8'h61;
    localparam logic [BYTE_W-1:0] ASCII_LC_Z  = 8'h7A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/char_row_writer_if.sv
// ----------------------------------------------------------------------------
// char_row_writer_if
// Bundles the host byte handshake, the row-memory write port and the status
// outputs of the character row writer.
//   in_byte/in_valid/in_ready : host byte stream (valid/ready)
//   wr_allow                  : display side grants a memory write this cycle
//   wr_en/wr_addr/wr_char     : single-cycle write strobe into the row memory
//   cursor/busy               : writer status
// Modports:
//   slave  - the writer (char_row_writer)
//   master - host + display side driving the writer
// ----------------------------------------------------------------------------
interface char_row_writer_if;
    import char_pkg::*;

    logic [BYTE_W-1:0]  in_byte;
    logic               in_valid;
    logic               in_ready;
    logic               wr_allow;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [GLYPH_W-1:0] wr_char;
    logic [ADDR_W-1:0]  cursor;
    logic               busy;

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        input  wr_allow,
        output wr_en,
        output wr_addr,
        output wr_char,
        output cursor,
        output busy
    );

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        output wr_allow,
        input  wr_en,
        input  wr_addr,
        input  wr_char,
        input  cursor,
        input  busy
    );

endinterface

// File: rtl/char_row_writer_ascii_to_glyph.sv
// ----------------------------------------------------------------------------
// ascii_to_glyph
// Purely combinational ASCII byte -> 6-bit glyph code mapper.
//   '0'-'9' -> 0..9, 'A'-'Z' -> 10..35, everything else -> BLANK.
// Build option:
//   CHAR_ROW_WRITER_LOWERCASE_EN defined : 'a'-'z' share the uppercase glyphs.
//   undefined (default)                  : 'a'-'z' map to BLANK.
// Ports:
//   i_byte    in  8  ASCII byte
//   o_glyph_c out 6  glyph code (combinational)
// ----------------------------------------------------------------------------
module ascii_to_glyph
    import char_pkg::*;
#(
    parameter logic [GLYPH_W-1:0] BLANK = char_pkg::BLANK_CODE
) (
    input  logic [BYTE_W-1:0]  i_byte,
    output logic [GLYPH_W-1:0] o_glyph_c
);

    // Range decode into glyph code
    always_comb begin
        o_glyph_c = BLANK;
        if ((i_byte >= ASCII_0) && (i_byte <= ASCII_9)) begin
            o_glyph_c = GLYPH_DIGIT0 + GLYPH_W'(i_byte - ASCII_0);
        end else if ((i_byte >= ASCII_UC_A) && (i_byte <= ASCII_UC_Z)) begin
            o_glyph_c = GLYPH_ALPHA_A + GLYPH_W'(i_byte - ASCII_UC_A);
`ifdef CHAR_ROW_WRITER_LOWERCASE_EN
        end else if ((i_byte >= ASCII_LC_A) && (i_byte <= ASCII_LC_Z)) begin
            o_glyph_c = GLYPH_ALPHA_A + GLYPH_W'(i_byte - ASCII_LC_A);
`endif
        end
    end

endmodule

// File: rtl/char_row_writer.sv
// ----------------------------------------------------------------------------
// char_row_writer
// Host-side writer for the character row buffer. Accepts ASCII bytes over a
// valid/ready handshake, maps them to glyph codes and issues single-cycle
// write strobes into the row memory while the display grants access.
// Supports cursor wrap, CR (cursor home), BS (erase previous cell) and FF
// (clear whole row).
// Build option: CHAR_ROW_WRITER_LOWERCASE_EN (handled in ascii_to_glyph).
// Parameters:
//   COLS       number of cells, 2..64
//   BLANK_CODE glyph code of an empty cell
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   slave modport of char_row_writer_if
//         (in_byte/in_valid/in_ready, wr_allow, wr_en/wr_addr/wr_char,
//          cursor, busy; all outputs registered)
// ----------------------------------------------------------------------------
module char_row_writer
    import char_pkg::*;
#(
    parameter int unsigned         COLS       = 64,
    parameter logic [GLYPH_W-1:0]  BLANK_CODE = char_pkg::BLANK_CODE
) (
    input  logic               clk,
    input  logic               rst,
    char_row_writer_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

    // Elaboration-time guard on the column count
    if ((COLS < 2) || (COLS > MAX_COLS)) begin : g_bad_cols
        $error("char_row_writer: COLS out of range 2..64");
    end

    state_t             r_state,     w_state_n;
    logic               r_in_ready,  w_in_ready_n;
    logic               r_wr_en,     w_wr_en_n;
    logic [ADDR_W-1:0]  r_wr_addr,   w_wr_addr_n;
    logic [GLYPH_W-1:0] r_wr_char,   w_wr_char_n;
    logic [ADDR_W-1:0]  r_cursor,    w_cursor_n;
    logic [ADDR_W-1:0]  r_clr_cnt,   w_clr_cnt_n;
    logic [GLYPH_W-1:0] r_pend_char, w_pend_char_n;
    logic               r_pend_adv,  w_pend_adv_n;
    logic               r_busy,      w_busy_n;

    logic [GLYPH_W-1:0] w_glyph;
    logic               w_accept;

    // Glyph lookup for the byte on the bus
    ascii_to_glyph #(
        .BLANK (BLANK_CODE)
    ) u_ascii_to_glyph (
        .i_byte    (bus.in_byte),
        .o_glyph_c (w_glyph)
    );

    // Handshake completes only in IDLE; in_ready already implies that
    assign w_accept = bus.in_valid && r_in_ready && (r_state == ST_IDLE);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_char   <= '0;
            r_cursor    <= '0;
            r_clr_cnt   <= '0;
            r_pend_char <= '0;
            r_pend_adv  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_in_ready  <= w_in_ready_n;
            r_wr_en     <= w_wr_en_n;
            r_wr_addr   <= w_wr_addr_n;
            r_wr_char   <= w_wr_char_n;
            r_cursor    <= w_cursor_n;
            r_clr_cnt   <= w_clr_cnt_n;
            r_pend_char <= w_pend_char_n;
            r_pend_adv  <= w_pend_adv_n;
            r_busy      <= w_busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_n     = r_state;
        w_wr_en_n     = 1'b0;
        w_wr_addr_n   = r_wr_addr;
        w_wr_char_n   = r_wr_char;
        w_cursor_n    = r_cursor;
        w_clr_cnt_n   = r_clr_cnt;
        w_pend_char_n = r_pend_char;
        w_pend_adv_n  = r_pend_adv;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (bus.in_byte == CR) begin
                        w_cursor_n = '0;
                    end else if (bus.in_byte == BS) begin
                        // Step back first; the blank lands on the new cursor
                        w_cursor_n    = (r_cursor == '0) ? '0 : (r_cursor - ADDR_W'(1));
                        w_pend_char_n = BLANK_CODE;
                        w_pend_adv_n  = 1'b0;
                        w_state_n     = ST_WRITE;
                    end else if (bus.in_byte == FF) begin
                        w_clr_cnt_n = '0;
                        w_state_n   = ST_CLEAR;
                    end else if (bus.in_byte >= ASCII_SPACE) begin
                        w_pend_char_n = w_glyph;
                        w_pend_adv_n  = 1'b1;
                        w_state_n     = ST_WRITE;
                    end
                    // Remaining control bytes are consumed silently
                end
            end

            ST_WRITE: begin
                if (bus.wr_allow) begin
                    w_wr_en_n   = 1'b1;
                    w_wr_addr_n = r_cursor;
                    w_wr_char_n = r_pend_char;
                    if (r_pend_adv) begin
                        w_cursor_n = (r_cursor == LAST_COL) ? '0 : (r_cursor + ADDR_W'(1));
                    end
                    w_state_n = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                if (bus.wr_allow) begin
                    w_wr_en_n   = 1'b1;
                    w_wr_addr_n = r_clr_cnt;
                    w_wr_char_n = BLANK_CODE;
                    if (r_clr_cnt == LAST_COL) begin
                        w_clr_cnt_n = '0;
                        w_cursor_n  = '0;
                        w_state_n   = ST_IDLE;
                    end else begin
                        w_clr_cnt_n = r_clr_cnt + ADDR_W'(1);
                    end
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        // Ready and busy follow the state we are about to enter
        w_in_ready_n = (w_state_n == ST_IDLE);
        w_busy_n     = (w_state_n != ST_IDLE);
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_char  = r_wr_char;
    assign bus.cursor   = r_cursor;
    assign bus.busy     = r_busy;

endmodule

// File: doc/char_row_writer.md
# char_row_writer

Host-side writer for the character row buffer. Accepts ASCII bytes from the Arduino command interface over a valid/ready handshake, converts them to 6-bit glyph codes, and issues single-cycle write strobes with cell address and glyph code into the row memory. Maintains a text cursor and supports carriage return, backspace and full-row clear. Writes are issued only while the display side grants access.

## Interface
Parameters:
- COLS, 64, number of character cells in the row; legal range 2..64.
- BLANK_CODE, 6'h3F, glyph code that renders as an empty cell.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_byte  in  8  ASCII byte from host.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  block can accept a byte; registered.
- wr_allow  in  1  display side permits a memory write this cycle.
- wr_en  out  1  one-cycle write strobe; registered.
- wr_addr  out  6  target cell, 0..COLS-1; registered.
- wr_char  out  6  glyph code to write; registered.
- cursor  out  6  current cursor cell, 0..COLS-1.
- busy  out  1  high in WRITE or CLEAR.

## Operation
- A byte is accepted on an edge with in_valid && in_ready. in_ready drops on that edge for any byte that needs a write.
- Glyph mapping: '0'-'9' -> 0..9; 'A'-'Z' -> 10..35; all other bytes >= 0x20, including space and 0x80-0xFF -> BLANK_CODE.
- Printable bytes (>= 0x20): go to WRITE. The write goes to addr = cursor. Cursor advances on the write edge and wraps COLS-1 -> 0.
- 0x0D (CR): cursor <= 0 on the accept edge. No write is issued, and in_ready stays 1.
- 0x08 (BS): cursor <= cursor-1, saturating at 0. Then go to WRITE and write BLANK_CODE at the new cursor. The cursor does not advance after this write.
- 0x0C (FF): go to CLEAR. Write BLANK_CODE to addresses 0..COLS-1 in ascending order. cursor <= 0 on the final write.
- Other bytes < 0x20: consumed and ignored. No write, no cursor change, and in_ready stays 1.
- FSM states are IDLE, WRITE and CLEAR:
  - IDLE -> WRITE on a printable or BS byte.
  - IDLE -> CLEAR on FF.
  - WRITE -> IDLE on the first edge with wr_allow = 1.
  - CLEAR -> IDLE on the edge that writes address COLS-1.
- If wr_allow is 0 in WRITE or CLEAR, the FSM stalls: wr_en stays 0 and the state is held. Low wr_allow cycles lose no data.

## Timing
- Reset values: in_ready = 0, wr_en = 0, wr_addr = 0, wr_char = 0, cursor = 0, busy = 0, state = IDLE, clear counter = 0.
- in_ready goes to 1 on the first edge after rst deasserts.
- Printable byte latency: accepted at edge E0. At edge E1 with wr_allow = 1, wr_en rises and wr_addr/wr_char become valid; in_ready returns to 1 on the same edge E1. wr_en falls at E2 unless a new write starts.
- Peak rate is one printable byte per 2 cycles.
- CLEAR takes exactly COLS edges with wr_allow = 1. wr_en stays high continuously if wr_allow is held high.
- rst during WRITE or CLEAR aborts immediately. No further wr_en is issued, and a partial clear is not resumed.
- in_valid while busy is not accepted; the host must hold its byte.

## Configuration
- CHAR_ROW_WRITER_LOWERCASE_EN defined: 'a'-'z' map to 10..35, the same glyphs as uppercase.
- CHAR_ROW_WRITER_LOWERCASE_EN undefined: 'a'-'z' map to BLANK_CODE. They are written and the cursor advances, as for any printable byte.

## Structure
- Package char_pkg holds:
  - the BLANK_CODE constant;
  - the glyph base constants GLYPH_DIGIT0 = 0 and GLYPH_ALPHA_A = 10;
  - the ASCII control constants CR, BS and FF;
  - the FSM state enum.
- Sub-module ascii_to_glyph is a purely combinational 8-bit -> 6-bit mapper. It also contains the lowercase macro guard.

## Test plan
- Reset, then send "A1" with wr_allow = 1: writes (addr 0, char 10) then (addr 1, char 1); cursor = 2; each wr_en lasts exactly 1 cycle.
- Send 64 printable bytes then 'Z': the 65th write goes to addr 0 with char 35; cursor = 1.
- Cursor at 5, send BS: write (addr 4, char 63); cursor = 4. Then send CR: no wr_en, cursor = 0. Then send BS: write (addr 0, char 63); cursor = 0.
- Send FF with wr_allow toggling every cycle: 64 writes in order 0..63, all char 63; in_ready low throughout; cursor = 0 at the end.
- Send 'a' under both macro settings: char 10 with CHAR_ROW_WRITER_LOWERCASE_EN defined, char 63 without it.
- Assert rst after the 10th write of a clear: no further wr_en; all outputs at reset values; a following 'B' writes (addr 0, char 11).
